// File: rtl/pwr_act_pkg.sv
// Shared types and helpers for the switching-activity counter: FSM state
// encoding, default sizing and a popcount used to accumulate total toggles.
package pwr_act_pkg;

  localparam int DEF_NUM_SIG = 4;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_WIN_W   = 16;
  localparam int MAX_SIG     = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Number of set bits; callers zero-extend their vector to MAX_SIG bits.
  function automatic int unsigned popcount(input logic [MAX_SIG-1:0] v);
    int unsigned n;
    n = 32'd0;
    for (int i = 0; i < MAX_SIG; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. sat flags an increment that
// had to be clamped, i.e. one attempted with no headroom left.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc_en,
  input  logic [W-1:0] inc_val,
  output logic [W-1:0] q,
  output logic         sat
);

  logic [W-1:0] r_q;
  logic [W:0]   w_sum;
  logic         w_clip;

  // Widened add exposes the carry that tells us the result must clamp.
  always_comb begin
    w_sum  = {1'b0, r_q} + {1'b0, inc_val};
    w_clip = w_sum[W];
  end

  // Counter register: reset/clear dominate, otherwise add with clamp.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= {W{1'b0}};
    end else if (clr) begin
      r_q <= {W{1'b0}};
    end else if (inc_en) begin
      r_q <= w_clip ? {W{1'b1}} : w_sum[W-1:0];
    end else begin
      r_q <= r_q;
    end
  end

  assign q   = r_q;
  assign sat = inc_en & w_clip & ~clr;

endmodule

// File: rtl/toggle_activity_counter.sv
// Counts per-net and total transitions on sampled nets over a programmed
// window of clock cycles; results hold until the next measurement starts.
module toggle_activity_counter
  import pwr_act_pkg::*;
#(
  parameter int NUM_SIG = DEF_NUM_SIG,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int WIN_W   = DEF_WIN_W,
  parameter int SEL_W   = (NUM_SIG > 1) ? $clog2(NUM_SIG) : 1,
  parameter int TOT_W   = CNT_W + SEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIN_W-1:0]   window_len,
  input  logic [NUM_SIG-1:0] sig_in,
  input  logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   toggle_cnt,
  output logic [TOT_W-1:0]   total_toggles,
  output logic               overflow
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_SIG-1:0] r_prev;
  logic [WIN_W-1:0]   r_remaining;
  logic               r_overflow;

  logic               w_clr;
  logic               w_counting;
  logic [NUM_SIG-1:0] w_toggle;
  logic [TOT_W-1:0]   w_pop;
  logic [NUM_SIG-1:0] w_net_sat;
  logic               w_tot_sat;
  logic [CNT_W-1:0]   w_cnt [NUM_SIG];
  logic [TOT_W-1:0]   w_total;

  // Next-state decode; a start is only honoured from IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_clr = 1'b1;
          if (window_len != {WIN_W{1'b0}}) begin
            w_state_nxt = ST_PRIME;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PRIME: w_state_nxt = ST_COUNT;
      ST_COUNT: begin
        if (r_remaining == {{(WIN_W-1){1'b0}}, 1'b1}) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_COUNT;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Window bookkeeping: previous sample, cycles left and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev      <= {NUM_SIG{1'b0}};
      r_remaining <= {WIN_W{1'b0}};
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_remaining <= window_len;
            r_overflow  <= 1'b0;
          end
        end
        ST_PRIME: r_prev <= sig_in;
        ST_COUNT: begin
          r_prev      <= sig_in;
          r_remaining <= r_remaining - {{(WIN_W-1){1'b0}}, 1'b1};
          if ((|w_net_sat) || w_tot_sat) begin
            r_overflow <= 1'b1;
          end
        end
        default: begin
          r_prev <= r_prev;
        end
      endcase
    end
  end

  assign w_counting = (r_state == ST_COUNT);
  assign w_toggle   = sig_in ^ r_prev;
  assign w_pop      = TOT_W'(popcount(MAX_SIG'(w_toggle)));

  for (genvar g = 0; g < NUM_SIG; g++) begin : g_net
    sat_counter #(
      .W(CNT_W)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     (w_clr),
      .inc_en  (w_counting & w_toggle[g]),
      .inc_val ({{(CNT_W-1){1'b0}}, 1'b1}),
      .q       (w_cnt[g]),
      .sat     (w_net_sat[g])
    );
  end

  sat_counter #(
    .W(TOT_W)
  ) u_total (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_clr),
    .inc_en  (w_counting),
    .inc_val (w_pop),
    .q       (w_total),
    .sat     (w_tot_sat)
  );

  // Out-of-range selects read as zero rather than aliasing another net.
  always_comb begin
    if (int'(sel) < NUM_SIG) begin
      toggle_cnt = w_cnt[sel];
    end else begin
      toggle_cnt = {CNT_W{1'b0}};
    end
  end

  assign busy          = (r_state == ST_PRIME) || (r_state == ST_COUNT);
  assign done          = (r_state == ST_DONE);
  assign total_toggles = w_total;
  assign overflow      = r_overflow;

endmodule

// File: doc/toggle_activity_counter.md
Name: toggle_activity_counter

Overview:
- Observes NUM_SIG digital nets, e.g. the a/b/sum/carry nets of the half adder.
- Counts 0→1 and 1→0 transitions per net over a programmed window of clock cycles.
- Consumes the switching activity that benches otherwise write out to VCD, and reports per-net and total toggle counts as the input to the power-estimation datapath.
- Single clock; results are held until the next measurement starts.

Parameters:
- NUM_SIG, 4, number of observed nets.
- CNT_W, 16, width of each per-net saturating toggle counter.
- WIN_W, 16, width of the window-length input.
- SEL_W, $clog2(NUM_SIG) (minimum 1), width of the result-select index.
- TOT_W, CNT_W+SEL_W, width of the total-toggle accumulator.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a measurement.
- window_len  in  WIN_W  number of compare cycles; sampled when start is accepted.
- sig_in  in  NUM_SIG  observed nets, one sample per clock.
- sel  in  SEL_W  index of the per-net count to read.
- busy  out  1  high in PRIME and COUNT.
- done  out  1  one-cycle pulse when results are valid.
- toggle_cnt  out  CNT_W  count for net sel (combinational read of the held result).
- total_toggles  out  TOT_W  sum of all toggles in the window.
- overflow  out  1  sticky: some counter saturated during the last window.

Behaviour:
- Reset (rst=1 at an edge, from any state, mid-window included):
  - state=IDLE; prev, all per-net counters, total_toggles, remaining all cleared to 0.
  - busy=0, done=0, overflow=0.
  - No done pulse is emitted for an aborted window.
- IDLE:
  - start=1 and window_len!=0 → PRIME. Latch remaining=window_len; clear counters, total, overflow.
  - start=1 and window_len==0 → DONE. Counts are cleared to 0.
  - start=0 → stay in IDLE.
- PRIME (1 cycle): prev<=sig_in → COUNT. No counting happens in this cycle.
- COUNT (exactly window_len cycles), each edge:
  - t=sig_in^prev.
  - For every bit i with t[i]=1: cnt[i]+=1, saturating at 2^CNT_W-1. An increment attempted at saturation sets overflow.
  - total += popcount(t), saturating at 2^TOT_W-1. Overflow sets on total saturation as well.
  - prev<=sig_in; remaining-=1.
  - Leave for DONE on the edge where remaining==1.
- DONE (1 cycle): done=1 → IDLE. Counts, total and overflow hold until the next accepted start or reset.
- Latency: start accepted at edge N; PRIME samples at N+1; COUNT edges N+2..N+1+W; done is high during the cycle after edge N+1+W.
- start while busy or in DONE: ignored. No restart and no change to window_len.
- sel>=NUM_SIG: toggle_cnt=0.
- Glitches between clock edges are not counted; only sampled values matter.

Decomposition:
- Package pwr_act_pkg holds:
  - state encoding (IDLE, PRIME, COUNT, DONE);
  - default parameter localparams;
  - a popcount function.
- One sub-module, sat_counter, with parameter W and ports clk, rst, clr, inc_en, inc_val, q, sat. It is instantiated NUM_SIG times with inc_val=1 and once for the total with inc_val=popcount.

Test Plan:
- Half-adder trace: sig_in={carry,sum,b,a}, start with window_len=4. Vectors {0000} (PRIME), then {0110},{1011},{1011},{0101}. Required: cnt a=1, b=2, sum=3, carry=2; total_toggles=8; overflow=0; done exactly 6 cycles after start.
- window_len=0 start → done pulses 1 cycle later; all counts 0; busy never asserted.
- CNT_W=4, sig_in[0] toggles every cycle, window_len=20 → cnt[0]=15, overflow=1, total_toggles=20 (TOT_W=6, no total saturation).
- rst asserted on the 3rd COUNT cycle of a 10-cycle window → next cycle IDLE; all outputs 0; no done pulse. A following start with window_len=2 and constant sig_in gives total_toggles=0.
- start pulsed again during COUNT with window_len=99 → ignored; original window length is honoured and done timing is unchanged.
- sel=0..3 read back after the half-adder trace gives 1,2,3,2. With NUM_SIG=3 and sel=3 → toggle_cnt=0.
